// File: rtl/uart_pkg.sv
// Shared UART MMIO constants: register addresses, CON bit positions and FSM encodings.
package uart_pkg;

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int unsigned CON_TX_IE    = 0;
    localparam int unsigned CON_RX_IE    = 1;
    localparam int unsigned CON_TX_DONE  = 2;
    localparam int unsigned CON_RX_VALID = 3;
    localparam int unsigned CON_TX_BUSY  = 4;
    localparam int unsigned CON_OVERRUN  = 5;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Bit-period counter width; counts 0..div-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// MEM-stage load/store bus between the CPU pipeline and the UART registers.
interface uart_mmio_if;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_data;

    modport master (output Address, Write_data, MemWrite, MemRead, input Read_data);
    modport slave  (input Address, Write_data, MemWrite, MemRead, output Read_data);
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: two-flop rx synchroniser, midpoint-sampling FSM, byte and one-cycle strobe.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_strobe
);

    localparam int unsigned CNT_W = cnt_width(BAUD_DIV);
    localparam int unsigned HALF  = (BAUD_DIV / 2 > 0) ? BAUD_DIV / 2 - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

    logic             rx_meta, rx_sync, rx_prev;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       rx_byte_nxt;
    logic             rx_strobe_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            rx_byte   <= rx_byte_nxt;
            rx_strobe <= rx_strobe_nxt;
        end
    end

    // Start bit confirmed at its midpoint, then every bit sampled one period later.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        rx_byte_nxt   = rx_byte;
        rx_strobe_nxt = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_nxt = RX_START;
                    cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = RX_IDLE;
                    if (rx_sync) begin
                        rx_byte_nxt   = shift;
                        rx_strobe_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART (TXD/RXD/CON) with level irq. Receiver present only when
// UART_RX_EN is defined; otherwise RX status reads 0 and rx is ignored.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 10417
) (
    input  logic       clk,
    input  logic       reset,
    uart_mmio_if.slave bus,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);

    localparam int unsigned CNT_W = cnt_width(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic txd_wr, con_wr, con_rd, rxd_rd;
    assign txd_wr = bus.MemWrite && (bus.Address == ADDR_TXD);
    assign con_wr = bus.MemWrite && (bus.Address == ADDR_CON);
    assign con_rd = bus.MemRead  && (bus.Address == ADDR_CON);
    assign rxd_rd = bus.MemRead  && (bus.Address == ADDR_RXD);

    logic [1:0]       tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic             tx_nxt, tx_frame_end, tx_busy;
    logic             tx_ie, rx_ie, tx_done, tx_done_nxt;
    logic             rx_valid, overrun, rx_strobe, irq_nxt;
    logic [7:0]       rx_byte;

    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            tx_ie    <= 1'b0;
            rx_ie    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            tx       <= tx_nxt;
            tx_done  <= tx_done_nxt;
            irq      <= irq_nxt;
            if (con_wr) begin
                tx_ie <= bus.Write_data[0];
                rx_ie <= bus.Write_data[1];
            end
        end
    end

    // Transmit FSM: tx is loaded with the next line level at each bit boundary.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_nxt       = tx;
        tx_frame_end = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (txd_wr) begin
                    tx_state_nxt = TX_START;
                    tx_shift_nxt = bus.Write_data[7:0];
                    tx_cnt_nxt   = '0;
                    tx_nxt       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_nxt       = tx_shift[0];
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    tx_state_nxt = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) begin
                        tx_nxt       = 1'b1;
                        tx_state_nxt = TX_STOP;
                    end else begin
                        tx_bit_nxt   = tx_bit + 3'd1;
                        tx_nxt       = tx_shift[0];
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                    tx_frame_end = 1'b1;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Set beats clear when both land on the same edge.
    always_comb begin
        tx_done_nxt = tx_done;
        if (con_rd)       tx_done_nxt = 1'b0;
        if (tx_frame_end) tx_done_nxt = 1'b1;
        irq_nxt = (tx_ie & tx_done) | (rx_ie & rx_valid);
    end

`ifdef UART_RX_EN
    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx_core (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (rx_strobe) begin
            rx_valid <= 1'b1;
            if (rx_valid) overrun <= 1'b1;
        end else if (rxd_rd) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end
`else
    assign rx_byte   = '0;
    assign rx_strobe = 1'b0;
    assign rx_valid  = 1'b0;
    assign overrun   = 1'b0;

    logic unused_rx;
    assign unused_rx = rx | rxd_rd | rx_strobe;
`endif

    logic [31:0] con_c;
    always_comb begin
        con_c               = '0;
        con_c[CON_TX_IE]    = tx_ie;
        con_c[CON_RX_IE]    = rx_ie;
        con_c[CON_TX_DONE]  = tx_done;
        con_c[CON_RX_VALID] = rx_valid;
        con_c[CON_TX_BUSY]  = tx_busy;
        con_c[CON_OVERRUN]  = overrun;
    end

    assign bus.Read_data = (bus.Address == ADDR_RXD) ? {24'd0, rx_byte} :
                           (bus.Address == ADDR_CON) ? con_c : 32'd0;

    logic unused_wdata;
    assign unused_wdata = ^bus.Write_data[31:8];

endmodule

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 10417, clk cycles per bit (100 MHz / 9600).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  reset: asynchronous, active-high.
REQ-004 SHALL have port Address  input  32  MEM-stage ALU result (byte address).
REQ-005 SHALL have port Write_data  input  32  MEM-stage store data.
REQ-006 SHALL have port MemWrite  input  1  store strobe, one cycle per store.
REQ-007 SHALL have port MemRead  input  1  load strobe, one cycle per load.
REQ-008 SHALL have port Read_data  output  32  combinational register read data; 0 when no register hit.
REQ-009 SHALL have port rx  input  1  serial in, asynchronous to clk.
REQ-010 SHALL have port tx  output  1  serial out, registered, idle high.
REQ-011 SHALL have port irq  output  1  level interrupt to the CPU, registered.

Function
REQ-012 SHALL decode TXD=0x40000018 (W), RXD=0x4000001C (R), CON=0x40000020 (R/W); other addresses are ignored.
REQ-013 SHALL expose CON as [0] tx_ie, [1] rx_ie (both R/W), [2] tx_done, [3] rx_valid, [4] tx_busy, [5] overrun (all read-only), upper bits 0.
REQ-014 SHALL present Read_data combinationally in the same cycle as Address; read side effects take place at the clock edge where MemRead is high.
REQ-015 SHALL, on a TXD write while tx_busy=0, latch Write_data[7:0], set tx_busy, and drive tx=0 (start bit) from that edge.
REQ-016 SHALL ignore TXD writes while tx_busy=1; no state changes.
REQ-017 SHALL run the TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE, holding each bit exactly BAUD_DIV cycles; STOP drives tx=1.
REQ-018 SHALL, at the edge ending STOP, clear tx_busy and set tx_done; a frame occupies exactly 10*BAUD_DIV cycles.
REQ-019 SHALL clear tx_done on a CON read; if tx_done is set on the same edge, the set wins.
REQ-020 SHALL synchronise rx through two flops before any use.
REQ-021 SHALL run the RX FSM IDLE->START->DATA->STOP: leave IDLE on a synchronised falling edge; re-sample at BAUD_DIV/2; if high (false start), return to IDLE.
REQ-022 SHALL sample each data bit, and then the stop bit, every BAUD_DIV cycles after the start-bit midpoint.
REQ-023 SHALL, on stop bit=1, load the RX byte and set rx_valid; if rx_valid was already 1, also set overrun; the new byte overwrites the old.
REQ-024 SHALL, on stop bit=0 (framing error), discard the byte and return to IDLE with flags unchanged.
REQ-025 SHALL clear rx_valid and overrun on an RXD read; if a new byte lands on the same edge, the new byte and the set win.
REQ-026 SHALL update irq each cycle as (tx_ie & tx_done) | (rx_ie & rx_valid), registered; irq is therefore visible one cycle after a flag changes.
REQ-027 SHALL write CON[1:0] from Write_data[1:0] on a CON store; writes to read-only bits have no effect.

Reset
REQ-028 SHALL, on reset, force tx=1, irq=0, all CON bits 0, the RX byte 0, both FSMs to IDLE and all counters to 0.
REQ-029 SHALL, on reset mid-frame, abort immediately and raise tx high at the reset assertion; no partial byte is retained.

Configuration
REQ-030 SHALL include the receiver only when UART_RX_EN is defined.
REQ-031 SHALL, without UART_RX_EN, omit the RX logic and synchronisers; RXD reads return 0, CON[3] and CON[5] read 0, rx_ie remains R/W but cannot raise irq, and rx is unused.

Structure
REQ-032 SHALL place the address constants, CON bit indices and FSM state encodings in shared package uart_pkg.
REQ-033 SHALL implement the receiver as sub-module uart_rx_core (synchroniser, FSM, byte and strobe outputs), instantiated only under UART_RX_EN.

Verification (BAUD_DIV=4)
REQ-034 SHALL cover: reset, then write TXD=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 (4 cycles each), tx_busy=1 for 40 cycles, then CON reads 0x04.
REQ-035 SHALL cover: CON=0x01, send one TX frame -> irq rises 1 cycle after tx_done sets; a CON read clears tx_done, and irq falls one cycle later.
REQ-036 SHALL cover: a second TXD write (0x3C) during a frame -> ignored, and the serial output is 0xA5 only.
REQ-037 SHALL cover: drive rx frame 0x5A, then read RXD -> 0x0000005A with rx_valid=1 before the read and 0 after.
REQ-038 SHALL cover: two rx frames (0x11, 0x22) with no read between -> RXD=0x22 and CON[5]=1; a 2-cycle low glitch on rx is treated as a false start with no flag change.
REQ-039 SHALL cover: reset asserted mid-TX at cycle 15 -> tx=1, CON=0, and a new TXD write after reset transmits normally.
